// File: rtl/commit_checker.sv
// Commit-trace monitor for the single-cycle MIPS cpu: taps the regfile and data-memory
// write ports and compares every architectural commit against a preloaded expected trace.
module commit_checker #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT      = 64,
  parameter bit STOP_ON_FAIL = 1'b1,
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [IDX_W-1:0]      load_idx,
  input  logic                  load_kind,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [IDX_W:0]        trace_len,
  input  logic                  start,
  input  logic                  rf_we,
  input  logic [4:0]            rf_waddr,
  input  logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic [IDX_W:0]        mismatch_count,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0]   DEPTH_LEN  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   COUNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic                    kind_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W:0]          len;
  logic [CNT_W-1:0]        idle_cnt;

  logic                    rf_ev;
  logic                    ev;
  logic                    match;
  logic                    last;
  logic [IDX_W:0]          start_len;
  logic [DATA_WIDTH-1:0]   obs_data;
  logic                    entry_kind;
  logic [ADDR_WIDTH-1:0]   entry_addr;
  logic [DATA_WIDTH-1:0]   entry_data;

  // Trace RAM has no reset so a loaded program survives a reset and can be re-run.
  always_ff @(posedge clock) begin
    if (load_en && state == IDLE) begin
      kind_mem[load_idx] <= load_kind;
      addr_mem[load_idx] <= load_addr;
      data_mem[load_idx] <= load_data;
    end
  end

  assign entry_kind = kind_mem[ptr];
  assign entry_addr = addr_mem[ptr];
  assign entry_data = data_mem[ptr];

  assign rf_ev     = rf_we && (rf_waddr != 5'd0);
  assign ev        = rf_ev || dm_we;
  assign obs_data  = rf_ev ? rf_wdata : dm_wdata;
  assign last      = ({1'b0, ptr} == len - 1'b1);
  assign start_len = (trace_len > DEPTH_LEN) ? DEPTH_LEN : trace_len;

  // A simultaneous register and memory write can never match a single trace entry.
  always_comb begin
    match = 1'b0;
    if (rf_ev && dm_we)
      match = 1'b0;
    else if (rf_ev)
      match = !entry_kind && (rf_waddr == entry_addr[4:0]) && (rf_wdata == entry_data);
    else if (dm_we)
      match = entry_kind && (dm_addr == entry_addr) && (dm_wdata == entry_data);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      len            <= '0;
      idle_cnt       <= '0;
      mismatch_count <= '0;
      fail_idx       <= '0;
      fail_data      <= '0;
      timed_out      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len            <= start_len;
            ptr            <= '0;
            idle_cnt       <= '0;
            mismatch_count <= '0;
            fail_idx       <= '0;
            fail_data      <= '0;
            timed_out      <= 1'b0;
            state          <= (start_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // An event on the would-be timeout cycle wins over the timeout.
          if (ev) begin
            ptr      <= ptr + 1'b1;
            idle_cnt <= '0;
            if (!match) begin
              if (mismatch_count != COUNT_MAX)
                mismatch_count <= mismatch_count + 1'b1;
              if (mismatch_count == '0) begin
                fail_idx  <= ptr;
                fail_data <= obs_data;
              end
            end
            if (last || (!match && STOP_ON_FAIL))
              state <= DONE;
          end else if (idle_cnt == IDLE_LIMIT) begin
            state     <= DONE;
            timed_out <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (mismatch_count == '0) && !timed_out;

endmodule

// File: tb/tb_commit_checker.sv
// Bench for commit_checker: two instances (stop-on-fail with short timeout, and run-to-end)
// share load and commit inputs; each vector's expected status is queued and checked after the edge.
module tb_commit_checker;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int IW    = 4;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          pass;
    logic          timed_out;
    logic [IW:0]   mcount;
    logic [IW-1:0] fidx;
    logic [DW-1:0] fdata;
  } st_t;

  typedef struct {
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    st_t           exp;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic          load_kind = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [IW:0]   trace_len = '0;
  logic          start_a = 1'b0;
  logic          start_b = 1'b0;
  logic          rf_we = 1'b0;
  logic [4:0]    rf_waddr = '0;
  logic [DW-1:0] rf_wdata = '0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;

  logic          busy_a, done_a, pass_a, to_a, busy_b, done_b, pass_b, to_b;
  logic [IW:0]   mc_a, mc_b;
  logic [IW-1:0] fi_a, fi_b;
  logic [DW-1:0] fd_a, fd_b;
  st_t           st_a, st_b;

  vec_t  vecs[$];
  st_t   expq[$];
  int    compared = 0;
  int    mismatched = 0;
  string tname;

  localparam logic [4:0] T0 = 5'd8, T1 = 5'd9, T2 = 5'd10;

  commit_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(4), .STOP_ON_FAIL(1'b1)) dut_a (
    .clock(clock), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_kind(load_kind),
    .load_addr(load_addr), .load_data(load_data), .trace_len(trace_len), .start(start_a),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .busy(busy_a), .done(done_a), .pass(pass_a), .timed_out(to_a),
    .mismatch_count(mc_a), .fail_idx(fi_a), .fail_data(fd_a));

  commit_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(8), .STOP_ON_FAIL(1'b0)) dut_b (
    .clock(clock), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_kind(load_kind),
    .load_addr(load_addr), .load_data(load_data), .trace_len(trace_len), .start(start_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .busy(busy_b), .done(done_b), .pass(pass_b), .timed_out(to_b),
    .mismatch_count(mc_b), .fail_idx(fi_b), .fail_data(fd_b));

  assign st_a = {busy_a, done_a, pass_a, to_a, mc_a, fi_a, fd_a};
  assign st_b = {busy_b, done_b, pass_b, to_b, mc_b, fi_b, fd_b};

  always #5 clock = ~clock;

  function automatic st_t mk(input logic b, input logic d, input logic p, input logic t,
                             input int mc, input int fi, input logic [DW-1:0] fd);
    st_t s;
    s.busy = b; s.done = d; s.pass = p; s.timed_out = t;
    s.mcount = (IW+1)'(mc); s.fidx = IW'(fi); s.fdata = fd;
    return s;
  endfunction

  function automatic vec_t vv(input logic rw, input logic [4:0] ra, input logic [DW-1:0] rd,
                              input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                              input st_t e);
    vec_t v;
    v.rf_we = rw; v.rf_waddr = ra; v.rf_wdata = rd;
    v.dm_we = dw; v.dm_addr = da; v.dm_wdata = dd; v.exp = e;
    return v;
  endfunction

  function automatic vec_t rfw(input logic [4:0] a, input logic [DW-1:0] d, input st_t e);
    return vv(1'b1, a, d, 1'b0, '0, '0, e);
  endfunction

  function automatic vec_t dmw(input logic [AW-1:0] a, input logic [DW-1:0] d, input st_t e);
    return vv(1'b0, 5'd0, '0, 1'b1, a, d, e);
  endfunction

  function automatic vec_t idl(input st_t e);
    return vv(1'b0, 5'd0, '0, 1'b0, '0, '0, e);
  endfunction

  task automatic checkOutput(input int which, input string what);
    st_t exp, act;
    exp = expq.pop_front();
    act = (which == 0) ? st_a : st_b;
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got busy=%0b done=%0b pass=%0b to=%0b mc=%0d fidx=%0d fdata=%0d, required busy=%0b done=%0b pass=%0b to=%0b mc=%0d fidx=%0d fdata=%0d",
               what, act.busy, act.done, act.pass, act.timed_out, act.mcount, act.fidx, act.fdata,
               exp.busy, exp.done, exp.pass, exp.timed_out, exp.mcount, exp.fidx, exp.fdata);
    end
  endtask

  task automatic applyStimulus(input int which);
    foreach (vecs[i]) begin
      rf_we = vecs[i].rf_we; rf_waddr = vecs[i].rf_waddr; rf_wdata = vecs[i].rf_wdata;
      dm_we = vecs[i].dm_we; dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      expq.push_back(vecs[i].exp);
      @(posedge clock); #1;
      checkOutput(which, $sformatf("%s step %0d", tname, i));
    end
    rf_we = 1'b0; dm_we = 1'b0; rf_waddr = '0; rf_wdata = '0; dm_addr = '0; dm_wdata = '0;
    vecs.delete();
  endtask

  task automatic doReset();
    reset = 1'b1;
    expq.push_back('0);
    expq.push_back('0);
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput(0, {tname, " reset A"});
    checkOutput(1, {tname, " reset B"});
  endtask

  task automatic loadEntry(input int idx, input logic kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en = 1'b1; load_idx = IW'(idx); load_kind = kind; load_addr = a; load_data = d;
    @(posedge clock); #1;
    load_en = 1'b0;
  endtask

  task automatic loadTrace1();
    loadEntry(0, 1'b0, 32'(T0), 32'd6);
    loadEntry(1, 1'b0, 32'(T1), 32'd11);
    loadEntry(2, 1'b0, 32'(T0), 32'd16);
    loadEntry(3, 1'b0, 32'(T2), 32'd251);
    loadEntry(4, 1'b0, 32'(T2), 32'd27);
  endtask

  task automatic startRun(input int which, input int len, input st_t e);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    trace_len = (IW+1)'(len);
    expq.push_back(e);
    @(posedge clock); #1;
    start_a = 1'b0; start_b = 1'b0;
    checkOutput(which, {tname, " start"});
  endtask

  initial begin
    st_t running, passed;
    running = mk(1, 0, 0, 0, 0, 0, 0);
    passed  = mk(0, 1, 1, 0, 0, 0, 0);

    tname = "t1_match";
    doReset();
    loadTrace1();
    startRun(0, 5, running);
    vecs.push_back(rfw(T0, 6, running));
    vecs.push_back(rfw(T1, 11, running));
    vecs.push_back(rfw(T0, 16, running));
    vecs.push_back(rfw(T2, 251, running));
    vecs.push_back(rfw(T2, 27, passed));
    vecs.push_back(rfw(T0, 1, passed));
    applyStimulus(0);

    tname = "t2_mixed";
    doReset();
    loadEntry(0, 1'b0, 32'(T0), 32'd5);
    loadEntry(1, 1'b0, 32'(T1), 32'd9);
    loadEntry(2, 1'b1, 32'd0, 32'd5);
    loadEntry(3, 1'b1, 32'd4, 32'd9);
    load_en = 1'b1; load_idx = 4'd4; load_kind = 1'b0; load_addr = 32'(T0); load_data = 32'd9;
    startRun(0, 5, running);
    load_en = 1'b0;
    vecs.push_back(rfw(T0, 5, running));
    vecs.push_back(idl(running));
    vecs.push_back(rfw(T1, 9, running));
    vecs.push_back(rfw(5'd0, 99, running));
    vecs.push_back(idl(running));
    vecs.push_back(dmw(0, 5, running));
    vecs.push_back(idl(running));
    vecs.push_back(dmw(4, 9, running));
    vecs.push_back(rfw(T0, 9, passed));
    applyStimulus(0);

    tname = "t3_stop";
    doReset();
    loadTrace1();
    startRun(0, 5, running);
    vecs.push_back(rfw(T0, 6, running));
    vecs.push_back(rfw(T1, 11, running));
    vecs.push_back(rfw(T0, 15, mk(0, 1, 0, 0, 1, 2, 15)));
    vecs.push_back(rfw(T2, 251, mk(0, 1, 0, 0, 1, 2, 15)));
    applyStimulus(0);

    tname = "t4_count";
    doReset();
    loadTrace1();
    startRun(1, 5, running);
    vecs.push_back(rfw(T0, 6, running));
    vecs.push_back(rfw(T1, 12, mk(1, 0, 0, 0, 1, 1, 12)));
    vecs.push_back(rfw(T0, 16, mk(1, 0, 0, 0, 1, 1, 12)));
    vecs.push_back(rfw(T2, 250, mk(1, 0, 0, 0, 2, 1, 12)));
    vecs.push_back(rfw(T2, 27, mk(0, 1, 0, 0, 2, 1, 12)));
    applyStimulus(1);

    tname = "t5_timeout";
    doReset();
    startRun(0, 3, running);
    vecs.push_back(rfw(T0, 6, running));
    vecs.push_back(idl(running));
    vecs.push_back(idl(running));
    vecs.push_back(idl(running));
    vecs.push_back(idl(mk(0, 1, 0, 1, 0, 0, 0)));
    applyStimulus(0);
    tname = "t5_len0";
    startRun(0, 0, passed);

    tname = "t6_both";
    doReset();
    startRun(1, 5, running);
    vecs.push_back(vv(1'b1, T0, 6, 1'b1, 0, 6, mk(1, 0, 0, 0, 1, 0, 6)));
    vecs.push_back(rfw(T1, 11, mk(1, 0, 0, 0, 1, 0, 6)));
    vecs.push_back(rfw(T0, 16, mk(1, 0, 0, 0, 1, 0, 6)));
    vecs.push_back(rfw(T2, 251, mk(1, 0, 0, 0, 1, 0, 6)));
    vecs.push_back(rfw(T2, 27, mk(0, 1, 0, 0, 1, 0, 6)));
    applyStimulus(1);

    tname = "t6_midreset";
    doReset();
    startRun(0, 5, running);
    vecs.push_back(rfw(T0, 6, running));
    applyStimulus(0);
    doReset();
    startRun(0, 5, running);
    load_en = 1'b1; load_idx = 4'd2; load_kind = 1'b0; load_addr = 32'(T0); load_data = 32'd99;
    vecs.push_back(rfw(T0, 6, running));
    vecs.push_back(rfw(T1, 11, running));
    vecs.push_back(rfw(T0, 16, running));
    vecs.push_back(rfw(T2, 251, running));
    vecs.push_back(rfw(T2, 27, passed));
    applyStimulus(0);
    load_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
